// File: rtl/vga_timing_ctrl_if.sv
// Pixel-request and DAC bundle for the VGA timing controller.
// The master side is the timing controller. It issues coordinates,
// accepts the returned colour, and drives the connector pins. The slave
// side is the view seen by the colour source and the DAC.
interface vga_timing_ctrl_if;
    // Request side: coordinates toward the colour source, colour back
    logic [9:0] oVGA_X;
    logic [9:0] oVGA_Y;
    logic       oRequest;
    logic       oFrame_Start;
    logic [9:0] iRed;
    logic [9:0] iGreen;
    logic [9:0] iBlue;

    // Connector / DAC side
    logic [9:0] oVGA_R;
    logic [9:0] oVGA_G;
    logic [9:0] oVGA_B;
    logic       oVGA_HS;
    logic       oVGA_VS;
    logic       oVGA_BLANK;

    modport master (
        output oVGA_X, oVGA_Y, oRequest, oFrame_Start,
        input  iRed, iGreen, iBlue,
        output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK
    );

    modport slave (
        input  oVGA_X, oVGA_Y, oRequest, oFrame_Start,
        output iRed, iGreen, iBlue,
        input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pixel-output stage.
// Stage 0 decodes the h/v counters into a coordinate request plus raw
// sync and active flags. Those flags ride a DATA_LAT-deep shift register
// so that they meet the colour returned by the source. A final output
// register then drives the pins. Colour, sync and blank therefore all
// reach the pins DATA_LAT+1 clocks after their request.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int DATA_LAT = 1,      // colour-source latency, 1..4
    parameter bit HS_POL   = 1'b0,   // active level of oVGA_HS
    parameter bit VS_POL   = 1'b0    // active level of oVGA_VS
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_N,
    vga_timing_ctrl_if.master vga
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Control flags carried alongside each request. hs/vs mean "sync
    // active" here; the pin polarity is applied only at the output register.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } ctl_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;

    ctl_t          w_ctl0;
    logic [9:0]    w_x;
    logic [9:0]    w_y;
    logic          w_frame_start;

    ctl_t          r_ctl_pipe [DATA_LAT];
    ctl_t          w_ctl_d;

    logic [9:0]    r_red;
    logic [9:0]    r_green;
    logic [9:0]    r_blue;
    logic          r_blank;
    logic          r_hs;
    logic          r_vs;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);

    // Pixel and line counters; v advances only when h wraps
    // NOTE: sequential state uses <= so every flop samples pre-edge values
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            if (w_v_wrap) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 1'b1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: request decode straight from the counters
    // ------------------------------------------------------------------
    // Decode visibility, raw sync windows and the coordinate request
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch)
        w_ctl0        = '0;
        w_x           = '0;
        w_y           = '0;
        w_frame_start = 1'b0;

        w_ctl0.act = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
        w_ctl0.hs  = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
        w_ctl0.vs  = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);

        // Coordinates are parked at 0 outside the visible area so the
        // colour source never sees an out-of-range address.
        if (w_ctl0.act) begin
            w_x = 10'(r_h_cnt);
            w_y = 10'(r_v_cnt);
        end

        w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    assign vga.oRequest     = w_ctl0.act;
    assign vga.oVGA_X       = w_x;
    assign vga.oVGA_Y       = w_y;
    assign vga.oFrame_Start = w_frame_start;

    // ------------------------------------------------------------------
    // Alignment pipeline: act/hs/vs wait for the colour source
    // ------------------------------------------------------------------
    // Shift the control flags DATA_LAT deep to match the colour latency
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: this small array is reset on purpose. A reset then drains
            // as blank with inactive sync instead of replaying stale pixels.
            for (int i = 0; i < DATA_LAT; i++) begin
                r_ctl_pipe[i] <= '0;
            end
        end else begin
            r_ctl_pipe[0] <= w_ctl0;
            for (int i = 1; i < DATA_LAT; i++) begin
                r_ctl_pipe[i] <= r_ctl_pipe[i-1];
            end
        end
    end

    assign w_ctl_d = r_ctl_pipe[DATA_LAT-1];

    // ------------------------------------------------------------------
    // Output register: blanking, polarity and pin drive
    // ------------------------------------------------------------------
    // Register pins; RGB is forced to zero whenever the delayed pixel is blank
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_blank <= 1'b0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
        end else begin
            r_red   <= w_ctl_d.act ? vga.iRed   : '0;
            r_green <= w_ctl_d.act ? vga.iGreen : '0;
            r_blue  <= w_ctl_d.act ? vga.iBlue  : '0;
            r_blank <= w_ctl_d.act;
            r_hs    <= w_ctl_d.hs ? HS_POL : ~HS_POL;
            r_vs    <= w_ctl_d.vs ? VS_POL : ~VS_POL;
        end
    end

    assign vga.oVGA_R     = r_red;
    assign vga.oVGA_G     = r_green;
    assign vga.oVGA_B     = r_blue;
    assign vga.oVGA_BLANK = r_blank;
    assign vga.oVGA_HS    = r_hs;
    assign vga.oVGA_VS    = r_vs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl.
// dut_a uses the default 640x480 timing with DATA_LAT=1 and covers line
// timing and data alignment. dut_b uses a shrunken raster with DATA_LAT=3
// and covers whole frames, vertical timing and a mid-frame reset.
// Expected pins are pushed to a scoreboard when the colour is driven and
// popped when the output register presents them.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    typedef struct {
        int h_act, h_fp, h_sw, h_bp;
        int v_act, v_fp, v_sw, v_bp;
        int lat;
    } tcfg_t;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       blank;
        logic       hs;
        logic       vs;
    } pins_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;

    always #5 clk = ~clk;

    vga_timing_ctrl_if if_a ();
    vga_timing_ctrl_if if_b ();

    vga_timing_ctrl #(
        .DATA_LAT (1)
    ) dut_a (
        .iVGA_CLK (clk),
        .iRST_N   (rst_a_n),
        .vga      (if_a)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (5),
        .V_ACTIVE (6),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .DATA_LAT (3)
    ) dut_b (
        .iVGA_CLK (clk),
        .iRST_N   (rst_b_n),
        .vga      (if_b)
    );

    tcfg_t    cfg;
    bit       sel;          // 0 = dut_a observed, 1 = dut_b observed
    int       n;            // cycle index since reset release
    int       func_from;    // first request served with a pattern colour
    int       n_checks = 0;
    int       n_pass   = 0;
    int       n_fail   = 0;

    pins_t      sb_q [$];
    pins_t      prev;
    int         blank_rise_q [$];
    int         blank_fall_q [$];
    int         hs_on_q [$];
    int         hs_off_q [$];
    int         vs_on_q [$];
    int         vs_off_q [$];
    int         fs_q [$];
    logic [9:0] r_hist [0:4095];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int h_tot();
        return cfg.h_act + cfg.h_fp + cfg.h_sw + cfg.h_bp;
    endfunction

    function automatic int v_tot();
        return cfg.v_act + cfg.v_fp + cfg.v_sw + cfg.v_bp;
    endfunction

    function automatic int q_at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic pins_t idle_pins();
        return '{r: 10'd0, g: 10'd0, b: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1};
    endfunction

    // Expected request-side view {req, frame_start, x, y} for request m
    function automatic logic [21:0] exp_stage0(input int m);
        int   h, v;
        logic act;
        h   = m % h_tot();
        v   = (m / h_tot()) % v_tot();
        act = (h < cfg.h_act) && (v < cfg.v_act);
        return {act, (h == 0) && (v == 0),
                act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0};
    endfunction

    // Colour-source model: a constant first, then a pattern of the requested X
    function automatic logic [29:0] src_colour(input int m);
        logic [21:0] s0;
        logic [9:0]  x;
        if (m < func_from) return {10'h3FF, 10'h3FF, 10'h3FF};
        s0 = exp_stage0(m);
        x  = s0[19:10];
        return {x ^ 10'h155, ~x, x + 10'd7};
    endfunction

    // Pins expected one output-register load after colour c was driven for request m
    function automatic pins_t exp_pins(input int m, input logic [29:0] c);
        pins_t p;
        int    h, v;
        logic  act;
        if (m < 0) return idle_pins();
        h   = m % h_tot();
        v   = (m / h_tot()) % v_tot();
        act = (h < cfg.h_act) && (v < cfg.v_act);
        p.r     = act ? c[29:20] : 10'd0;
        p.g     = act ? c[19:10] : 10'd0;
        p.b     = act ? c[9:0]   : 10'd0;
        p.blank = act;
        p.hs    = ((h >= cfg.h_act + cfg.h_fp) && (h < cfg.h_act + cfg.h_fp + cfg.h_sw)) ? 1'b0 : 1'b1;
        p.vs    = ((v >= cfg.v_act + cfg.v_fp) && (v < cfg.v_act + cfg.v_fp + cfg.v_sw)) ? 1'b0 : 1'b1;
        return p;
    endfunction

    function automatic pins_t get_pins();
        if (sel) return {if_b.oVGA_R, if_b.oVGA_G, if_b.oVGA_B, if_b.oVGA_BLANK, if_b.oVGA_HS, if_b.oVGA_VS};
        return {if_a.oVGA_R, if_a.oVGA_G, if_a.oVGA_B, if_a.oVGA_BLANK, if_a.oVGA_HS, if_a.oVGA_VS};
    endfunction

    function automatic logic [21:0] get_s0();
        if (sel) return {if_b.oRequest, if_b.oFrame_Start, if_b.oVGA_X, if_b.oVGA_Y};
        return {if_a.oRequest, if_a.oFrame_Start, if_a.oVGA_X, if_a.oVGA_Y};
    endfunction

    // One cycle at the negedge: compare, log edges, drive colour, push expectation
    task automatic step();
        pins_t       obs;
        logic [21:0] s0;
        logic [29:0] c;
        int          m;
        obs = get_pins();
        s0  = get_s0();
        check("stage0", 64'(s0), 64'(exp_stage0(n)));
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) check("pins", 64'(obs), 64'(sb_q.pop_front()));

        if (n > 0) begin
            if ( obs.blank && !prev.blank) blank_rise_q.push_back(n);
            if (!obs.blank &&  prev.blank) blank_fall_q.push_back(n);
            if (!obs.hs    &&  prev.hs)    hs_on_q.push_back(n);
            if ( obs.hs    && !prev.hs)    hs_off_q.push_back(n);
            if (!obs.vs    &&  prev.vs)    vs_on_q.push_back(n);
            if ( obs.vs    && !prev.vs)    vs_off_q.push_back(n);
        end
        if (s0[20]) fs_q.push_back(n);
        if (n < 4096) r_hist[n] = obs.r;
        prev = obs;

        m = n - cfg.lat;
        c = src_colour(m);
        {if_a.iRed, if_a.iGreen, if_a.iBlue} = c;
        {if_b.iRed, if_b.iGreen, if_b.iBlue} = c;
        sb_q.push_back(exp_pins(m, c));
        n++;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            step();
        end
    endtask

    // Release the selected DUT just after an edge; cycle 0 is sampled at the next negedge
    task automatic release_reset();
        @(posedge clk);
        #1;
        if (sel) rst_b_n = 1'b1;
        else     rst_a_n = 1'b1;
        n = 0;
        sb_q.delete();
        sb_q.push_back(idle_pins());
        prev = idle_pins();
        blank_rise_q.delete(); blank_fall_q.delete();
        hs_on_q.delete();      hs_off_q.delete();
        vs_on_q.delete();      vs_off_q.delete();
        fs_q.delete();
    endtask

    // Line-level timing measured on the pins
    task automatic check_line_timing();
        int lat1;
        lat1 = cfg.lat + 1;
        check("fs_first",      64'(q_at(fs_q, 0)), 64'd0);
        check("blank_rise",    64'(q_at(blank_rise_q, 0)), 64'(lat1));
        check("rgb_first",     64'(r_hist[lat1]), 64'h3FF);
        check("visible_len",   64'(q_at(blank_fall_q, 0) - q_at(blank_rise_q, 0)), 64'(cfg.h_act));
        check("hs_front",      64'(q_at(hs_on_q, 0) - q_at(blank_fall_q, 0)), 64'(cfg.h_fp));
        check("hs_width",      64'(q_at(hs_off_q, 0) - q_at(hs_on_q, 0)), 64'(cfg.h_sw));
        check("hs_back",       64'(q_at(blank_rise_q, 1) - q_at(hs_off_q, 0)), 64'(cfg.h_bp));
        check("line_period",   64'(q_at(blank_rise_q, 1) - q_at(blank_rise_q, 0)), 64'(h_tot()));
        check("hs_period",     64'(q_at(hs_on_q, 1) - q_at(hs_on_q, 0)), 64'(h_tot()));
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        {if_a.iRed, if_a.iGreen, if_a.iBlue} = '0;
        {if_b.iRed, if_b.iGreen, if_b.iBlue} = '0;

        // ---- dut_a: default 640x480 timing, DATA_LAT = 1 ----
        sel       = 1'b0;
        cfg       = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
        func_from = 800;
        n         = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pins_a",  64'(get_pins()), 64'(idle_pins()));
        check("rst_stage0_a", 64'(get_s0()), 64'(exp_stage0(0)));

        release_reset();
        run(1700);
        check_line_timing();
        // Column 639 of line 1 reaches the pins at 800+639+2, column 640 one clock later
        check("col639_r", 64'(r_hist[1441]), 64'(10'd639 ^ 10'h155));
        check("col640_r", 64'(r_hist[1442]), 64'd0);

        // ---- dut_b: reduced raster (31 x 13), DATA_LAT = 3 ----
        rst_a_n   = 1'b0;
        sel       = 1'b1;
        cfg       = '{16, 4, 6, 5, 6, 2, 2, 3, 3};
        func_from = 403;
        @(negedge clk);
        check("rst_pins_b", 64'(get_pins()), 64'(idle_pins()));

        release_reset();
        run(850);
        check_line_timing();
        check("vs_start",      64'(q_at(vs_on_q, 0)), 64'((cfg.v_act + cfg.v_fp) * h_tot() + cfg.lat + 1));
        check("vs_width",      64'(q_at(vs_off_q, 0) - q_at(vs_on_q, 0)), 64'(cfg.v_sw * h_tot()));
        check("vs_period",     64'(q_at(vs_on_q, 1) - q_at(vs_on_q, 0)), 64'(h_tot() * v_tot()));
        check("fs_period",     64'(q_at(fs_q, 1) - q_at(fs_q, 0)), 64'(h_tot() * v_tot()));

        // ---- mid-frame reset at h=12, v=3 ----
        while ((n % (h_tot() * v_tot())) != (3 * h_tot() + 12)) run(1);
        @(negedge clk);
        check("pre_rst_xy",    64'({if_b.oVGA_X, if_b.oVGA_Y}), 64'({10'd12, 10'd3}));
        check("pre_rst_blank", 64'(if_b.oVGA_BLANK), 64'd1);
        #1;
        rst_b_n = 1'b0;
        #1;
        check("async_pins",    64'(get_pins()), 64'(idle_pins()));
        check("async_stage0",  64'(get_s0()), 64'(exp_stage0(0)));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("held_pins",     64'(get_pins()), 64'(idle_pins()));

        release_reset();
        run(120);
        check("rst_fs_first",    64'(q_at(fs_q, 0)), 64'd0);
        check("rst_blank_rise",  64'(q_at(blank_rise_q, 0)), 64'(cfg.lat + 1));
        check("rst_rgb_first",   64'(r_hist[cfg.lat + 1]), 64'h3FF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
VGA raster timing generator and pixel-output stage for the DE1 default display path.
- Scans a programmable 640x480@60 Hz-class raster and issues per-pixel X/Y coordinate requests to the downstream colour source (the pattern generator, 10-bit RGB, registered, fixed latency).
- Accepts the returned RGB and drives the DAC/connector signals: RGB, HS, VS, BLANK.
- Delays sync and blank by the colour-source latency so they stay pixel-aligned with the returned colour.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
DATA_LAT, 1, clocks from request to valid iRed/iGreen/iBlue (range 1..4)
HS_POL, 0, active level of oVGA_HS
VS_POL, 0, active level of oVGA_VS

Ports:
iVGA_CLK  in  1  pixel clock
iRST_N  in  1  asynchronous active-low reset
iRed  in  10  red from colour source
iGreen  in  10  green from colour source
iBlue  in  10  blue from colour source
oVGA_X  out  10  requested pixel column
oVGA_Y  out  10  requested pixel row
oRequest  out  1  high when oVGA_X/oVGA_Y address a visible pixel
oFrame_Start  out  1  one-cycle pulse at request of pixel (0,0)
oVGA_R  out  10  red to DAC
oVGA_G  out  10  green to DAC
oVGA_B  out  10  blue to DAC
oVGA_HS  out  1  horizontal sync
oVGA_VS  out  1  vertical sync
oVGA_BLANK  out  1  active-low blank (1 = visible)

Behaviour:
- Reset: iRST_N, asynchronous, active-low; clock iVGA_CLK; all flops on posedge iVGA_CLK.
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on h_cnt wrap; it runs 0..V_TOTAL-1 and wraps to 0 together with h_cnt.
- Region order per line/frame: active, front porch, sync, back porch.
- Request stage (stage 0, directly from the counters):
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - oRequest = act.
  - oVGA_X = act ? h_cnt : 0; oVGA_Y = act ? v_cnt : 0.
  - oFrame_Start = (h_cnt == 0 && v_cnt == 0).
- Sync generation at stage 0:
  - hs0 active when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vs0 active when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (490..491). VS edges therefore coincide with h_cnt = 0.
- Alignment pipeline:
  - act, hs0 and vs0 pass through a DATA_LAT-deep shift register.
  - Colour for the stage-0 request is sampled on iRed/iGreen/iBlue DATA_LAT cycles later.
  - The output register then loads:
    - oVGA_R/G/B = delayed act ? input colour : 0.
    - oVGA_BLANK = delayed act.
    - oVGA_HS = delayed hs0 ? HS_POL : ~HS_POL (VS likewise with VS_POL).
  - Total latency from request to pins: DATA_LAT+1 clocks for colour, sync and blank alike.
- Blanking rule: RGB is forced to 0 whenever blank, regardless of input value.
- Reset values:
  - h_cnt = v_cnt = 0.
  - Shift-register contents: act = 0, hs = vs = inactive.
  - oVGA_R/G/B = 0, oVGA_BLANK = 0, oVGA_HS = ~HS_POL, oVGA_VS = ~VS_POL.
  - oRequest/oVGA_X/oVGA_Y/oFrame_Start follow the counters. Because the counters reset to 0, oRequest=1, oFrame_Start=1, X=Y=0 are driven during and immediately after reset; downstream treats these as don't-care while in reset.
- Reset mid-frame: counters restart at (0,0) on the first clock after deassertion. The pipeline drains blank, so no partial pixels appear.
- Coordinates never exceed H_ACTIVE-1 / V_ACTIVE-1 and fit in 10 bits for the default parameters.

Test Plan:
1. Reset release, DATA_LAT=1, iRed=iGreen=iBlue=0x3FF constant:
   - oFrame_Start high on the first clock after deassertion.
   - oVGA_BLANK rises exactly 2 clocks later with RGB = 0x3FF.
   - Line has 640 visible clocks, then 160 blank clocks with RGB = 0.
2. Horizontal timing: measure over one line.
   - oVGA_HS low for 96 clocks.
   - Falling edge 16 clocks after BLANK falls; BLANK rises 48 clocks after HS rises.
   - Period 800 clocks.
3. Vertical timing: run two full frames.
   - oVGA_VS low for 2 lines (1600 clocks), starting 10 lines after the last visible line.
   - Frame = 420000 clocks; oFrame_Start spacing 420000.
4. Data alignment: model iRed = registered function of oVGA_X (the colour source with 1-cycle latency).
   - Pin oVGA_R at visible column 639 matches the value for X=639.
   - Column 640 yields R = 0 even with non-zero input.
5. DATA_LAT=3 build: same stimulus as scenario 1.
   - Colour/BLANK/HS/VS all shifted to 4-clock latency; relative HS/BLANK spacing unchanged from scenario 2.
6. Assert iRST_N low at h_cnt=300, v_cnt=200 for 5 clocks:
   - Outputs go to reset values immediately (asynchronous).
   - After release, oFrame_Start pulses on the first clock; first visible pixel reaches the pins DATA_LAT+1 clocks later.
